stage_fetch_q: RTL and testbench



---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_queue.sv | 62 ++++++
 rtl/stage_fetch_q.sv | 139 +++++++++++++
 tb/tb_stage_fetch_q.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// fetch_pkg : shared constants and entry type for the fetch stage
// Rev 1.0
// ==========================================================================
package fetch_pkg;

  localparam int                  DEF_XLEN     = 32;
  localparam logic [DEF_XLEN-1:0] DEF_RESET_PC = 32'h8000_0000;
  localparam int                  CTRL_BIT     = 6;

  typedef struct packed {
    logic [DEF_XLEN-1:0] pc;
    logic [DEF_XLEN-1:0] insn;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// fetch_queue : synchronous FIFO of fetch entries with push/pop/flush
// Rev 1.0
// ==========================================================================
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  T                       din_i,
  output T                       dout_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o,
  output logic                   full_o
);

  localparam int AW = $clog2(DEPTH);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n || flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + AW'(1);
      if (pop_i)  rd_q <= rd_q + AW'(1);
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == (AW+1)'(DEPTH));

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
                                  !(push_i && full_o && !flush_i));

endmodule
`default_nettype wire

// File: rtl/stage_fetch_q.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// stage_fetch_q : instruction fetch with prefetch queue and redirect/drop
// Rev 1.0
// ==========================================================================
module stage_fetch_q
  import fetch_pkg::*;
#(
  parameter int              XLEN         = DEF_XLEN,
  parameter int              DEPTH        = 4,
  parameter logic [XLEN-1:0] RESET_PC     = XLEN'(DEF_RESET_PC),
  parameter bit              STOP_ON_CTRL = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   de_stall,
  input  logic                   fe_enable,
  input  logic                   pc_wen,
  input  logic [XLEN-1:0]        pc_in,
  output logic                   req,
  output logic [XLEN-1:0]        addr,
  input  logic                   ack,
  input  logic [XLEN-1:0]        data,
  output logic                   de_valid,
  output logic [XLEN-1:0]        de_insn,
  output logic [XLEN-1:0]        de_pc,
  output logic [$clog2(DEPTH):0] q_count
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] insn;
  } entry_t;

  logic [XLEN-1:0] fpc_q, fpc_d, rpc_q, rpc_d, w_target;
  logic            active_q, active_d, drop_q, drop_d, dv_q, dv_d;
  entry_t          out_q, out_d, w_entry, w_head;
  logic            w_ack, w_deliver, w_load, w_push, w_pop, w_credit;
  logic            q_empty, q_full;

  // Output register plus a full queue is exactly DEPTH+1 held entries.
  assign w_credit  = !(q_full && dv_q);
  assign req       = reset_n && ((active_q && w_credit) || drop_q);
  assign addr      = fpc_q;
  assign w_ack     = ack && req;
  assign w_deliver = w_ack && !drop_q && !fe_enable;
  assign w_load    = !dv_q || !de_stall;
  assign w_entry   = '{pc: fpc_q, insn: data};

  always_comb begin
    fpc_d    = fpc_q;
    rpc_d    = rpc_q;
    active_d = active_q;
    drop_d   = drop_q;
    dv_d     = dv_q;
    out_d    = out_q;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    w_target = pc_wen ? pc_in : fpc_q;
    if (fe_enable) begin
      dv_d     = dv_q && de_stall;
      active_d = 1'b1;
      // An unanswered request must finish before the new target can be used.
      if (req && !ack) begin
        drop_d = 1'b1;
        rpc_d  = w_target;
      end else begin
        drop_d = 1'b0;
        fpc_d  = w_target;
      end
    end else begin
      if (w_ack) begin
        if (drop_q) begin
          fpc_d  = rpc_q;
          drop_d = 1'b0;
        end else begin
          fpc_d = fpc_q + XLEN'(4);
          if (STOP_ON_CTRL && data[CTRL_BIT]) active_d = 1'b0;
        end
      end
      if (w_load) begin
        if (!q_empty) begin
          out_d  = w_head;
          dv_d   = 1'b1;
          w_pop  = 1'b1;
          w_push = w_deliver;
        end else if (w_deliver) begin
          out_d = w_entry;
          dv_d  = 1'b1;
        end else begin
          dv_d = 1'b0;
        end
      end else begin
        w_push = w_deliver;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fpc_q    <= RESET_PC;
      rpc_q    <= RESET_PC;
      active_q <= 1'b1;
      drop_q   <= 1'b0;
      dv_q     <= 1'b0;
      out_q    <= '0;
    end else begin
      fpc_q    <= fpc_d;
      rpc_q    <= rpc_d;
      active_q <= active_d;
      drop_q   <= drop_d;
      dv_q     <= dv_d;
      out_q    <= out_d;
    end
  end

  fetch_queue #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (fe_enable),
    .din_i   (w_entry),
    .dout_o  (w_head),
    .count_o (q_count),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

  assign de_valid = dv_q;
  assign de_insn  = out_q.insn;
  assign de_pc    = out_q.pc;

endmodule
`default_nettype wire

// File: tb/tb_stage_fetch_q.sv
`timescale 1ns/1ps
`default_nettype none
// ==========================================================================
// tb_stage_fetch_q : scenario tasks plus randomized stream vs in-order model
// Rev 1.0
// ==========================================================================
module tb_stage_fetch_q;

  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] JUNK   = 32'h0BAD_F00D;

  logic        clk = 1'b0;
  logic        reset_n, de_stall, fe_enable, pc_wen, ack, req, de_valid;
  logic [31:0] pc_in, addr, data, de_insn, de_pc;
  logic [2:0]  q_count;

  int          n_vec = 0;
  int          n_err = 0;
  bit          mem_auto, ctrl_on;
  int          mem_lat, mem_maxlat;
  logic [31:0] ctrl_pc;

  always #5 clk = ~clk;

  stage_fetch_q #(
    .XLEN(32), .DEPTH(DEPTH), .RESET_PC(RST_PC), .STOP_ON_CTRL(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .de_stall(de_stall), .fe_enable(fe_enable),
    .pc_wen(pc_wen), .pc_in(pc_in), .req(req), .addr(addr), .ack(ack),
    .data(data), .de_valid(de_valid), .de_insn(de_insn), .de_pc(de_pc),
    .q_count(q_count)
  );

  // Memory image: scrambled words with bit 6 clear, except an optional jal.
  function automatic logic [31:0] insn_of(input logic [31:0] pc);
    if (ctrl_on && pc == ctrl_pc) return 32'h0000_006F;
    return ((pc ^ 32'h1357_9BDF) * 32'h9E37_79B1) & ~32'h0000_0040;
  endfunction

  task automatic drive_mem();
    if (mem_auto && req) begin
      if (mem_lat == 0) begin
        ack     = 1'b1;
        data    = insn_of(addr);
        mem_lat = $urandom_range(mem_maxlat, 0);
      end else begin
        ack     = 1'b0;
        data    = $urandom;
        mem_lat = mem_lat - 1;
      end
    end else begin
      ack = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0; de_stall = 1'b0; fe_enable = 1'b0; pc_wen = 1'b0;
    pc_in = '0; ack = 1'b0; data = '0;
    mem_auto = 1'b0; mem_maxlat = 0; mem_lat = 0; ctrl_on = 1'b0; ctrl_pc = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0; de_stall = 1'b0; fe_enable = 1'b0; pc_wen = 1'b0;
    pc_in = '0; ack = 1'b0; data = '0;
    @(negedge clk);
    n_vec++;
    if (req !== 1'b0 || de_valid !== 1'b0 || q_count !== 3'd0) begin
      n_err++;
      $display("FAIL reset_state: req=%b de_valid=%b q_count=%0d, want 0 0 0", req, de_valid, q_count);
    end
    reset_n = 1'b1;
    @(negedge clk);
    n_vec++;
    if (req !== 1'b1 || addr !== RST_PC || de_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_first_req: req=%b addr=%h de_valid=%b, want 1 %h 0", req, addr, de_valid, RST_PC);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] ea;
    do_reset();
    ea = RST_PC;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_vec++;
      if (req !== 1'b1 || addr !== ea) begin
        n_err++;
        $display("FAIL seq_req[%0d]: req=%b addr=%h, want 1 %h", i, req, addr, ea);
      end
      if (i > 0) begin
        n_vec++;
        if (de_valid !== 1'b1 || de_pc !== ea - 32'd4 || de_insn !== insn_of(ea - 32'd4)) begin
          n_err++;
          $display("FAIL seq_out[%0d]: valid=%b pc=%h insn=%h, want 1 %h %h", i, de_valid, de_pc,
                   de_insn, ea - 32'd4, insn_of(ea - 32'd4));
        end
      end
      n_vec++;
      if (q_count !== 3'd0) begin
        n_err++;
        $display("FAIL seq_qcount[%0d]: got %0d want 0", i, q_count);
      end
      ack = 1'b1; data = insn_of(ea); ea = ea + 32'd4;
    end
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_stall_fill();
    int nack;
    do_reset();
    nack = 0; de_stall = 1'b1; mem_auto = 1'b1;
    repeat (10) begin
      @(negedge clk);
      drive_mem();
      if (ack) nack++;
    end
    @(negedge clk);
    n_vec++;
    if (nack != DEPTH + 1 || q_count !== 3'(DEPTH) || req !== 1'b0 || de_valid !== 1'b1 || de_pc !== RST_PC) begin
      n_err++;
      $display("FAIL stall_fill: acks=%0d q=%0d req=%b valid=%b pc=%h, want 5 4 0 1 %h",
               nack, q_count, req, de_valid, de_pc, RST_PC);
    end
    de_stall = 1'b0;
    drive_mem();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      n_vec++;
      if (de_valid !== 1'b1 || de_pc !== RST_PC + 32'(4 * k) || de_insn !== insn_of(RST_PC + 32'(4 * k))) begin
        n_err++;
        $display("FAIL stall_drain[%0d]: valid=%b pc=%h insn=%h, want 1 %h", k, de_valid, de_pc,
                 de_insn, RST_PC + 32'(4 * k));
      end
      if (k == 1) begin
        n_vec++;
        if (req !== 1'b1 || addr !== RST_PC + 32'd20) begin
          n_err++;
          $display("FAIL stall_resume: req=%b addr=%h, want 1 %h", req, addr, RST_PC + 32'd20);
        end
      end
      drive_mem();
    end
    mem_auto = 1'b0;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_stop_on_ctrl();
    do_reset();
    ctrl_on = 1'b1; ctrl_pc = RST_PC + 32'd8; mem_auto = 1'b1;
    repeat (3) begin
      @(negedge clk);
      drive_mem();
    end
    @(negedge clk);
    n_vec++;
    if (req !== 1'b0 || de_valid !== 1'b1 || de_pc !== ctrl_pc || de_insn !== 32'h0000_006F) begin
      n_err++;
      $display("FAIL ctrl_stop: req=%b valid=%b pc=%h insn=%h, want 0 1 %h 0000006f",
               req, de_valid, de_pc, de_insn, ctrl_pc);
    end
    repeat (3) begin
      @(negedge clk);
      n_vec++;
      if (req !== 1'b0) begin
        n_err++;
        $display("FAIL ctrl_idle: req=%b want 0", req);
      end
    end
    fe_enable = 1'b1; pc_wen = 1'b1; pc_in = 32'h8000_0100;
    @(negedge clk);
    fe_enable = 1'b0; pc_wen = 1'b0;
    n_vec++;
    if (req !== 1'b1 || addr !== 32'h8000_0100) begin
      n_err++;
      $display("FAIL ctrl_redirect: req=%b addr=%h, want 1 80000100", req, addr);
    end
    drive_mem();
    @(negedge clk);
    n_vec++;
    if (de_valid !== 1'b1 || de_pc !== 32'h8000_0100 || de_insn !== insn_of(32'h8000_0100)) begin
      n_err++;
      $display("FAIL ctrl_target_out: valid=%b pc=%h insn=%h, want 1 80000100 %h",
               de_valid, de_pc, de_insn, insn_of(32'h8000_0100));
    end
    mem_auto = 1'b0;
    ack = 1'b0;
  endtask

  task automatic test_redirect_drop();
    bit found, seen;
    do_reset();
    found = 1'b0; seen = 1'b0; mem_auto = 1'b1;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (req && addr == RST_PC + 32'd16) found = 1'b1;
      else drive_mem();
    end
    n_vec++;
    if (!found) begin
      n_err++;
      $display("FAIL drop_reach: request to %h never seen within 20 cycles", RST_PC + 32'd16);
      mem_auto = 1'b0; ack = 1'b0;
      return;
    end
    mem_auto = 1'b0; ack = 1'b0;
    fe_enable = 1'b1; pc_wen = 1'b1; pc_in = 32'h8000_0200;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      fe_enable = 1'b0; pc_wen = 1'b0;
      if (de_valid === 1'b1 && de_insn === JUNK) seen = 1'b1;
      n_vec++;
      if (req !== 1'b1 || addr !== RST_PC + 32'd16 || (k == 1 && de_valid !== 1'b0)) begin
        n_err++;
        $display("FAIL drop_hold[%0d]: req=%b addr=%h valid=%b, want 1 %h (valid 0 first)",
                 k, req, addr, de_valid, RST_PC + 32'd16);
      end
      if (k == 3) begin
        ack = 1'b1; data = JUNK;
      end
    end
    @(negedge clk);
    ack = 1'b0;
    if (de_valid === 1'b1 && de_insn === JUNK) seen = 1'b1;
    n_vec++;
    if (req !== 1'b1 || addr !== 32'h8000_0200 || de_valid !== 1'b0) begin
      n_err++;
      $display("FAIL drop_new_req: req=%b addr=%h valid=%b, want 1 80000200 0", req, addr, de_valid);
    end
    ack = 1'b1; data = insn_of(32'h8000_0200);
    @(negedge clk);
    ack = 1'b0;
    if (de_valid === 1'b1 && de_insn === JUNK) seen = 1'b1;
    n_vec++;
    if (de_valid !== 1'b1 || de_pc !== 32'h8000_0200 || de_insn !== insn_of(32'h8000_0200)) begin
      n_err++;
      $display("FAIL drop_target_out: valid=%b pc=%h insn=%h, want 1 80000200 %h",
               de_valid, de_pc, de_insn, insn_of(32'h8000_0200));
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL drop_discard: discarded word %h reached de_insn", JUNK);
    end
  endtask

  task automatic test_flush_stalled();
    do_reset();
    de_stall = 1'b1; mem_auto = 1'b1;
    repeat (4) begin
      @(negedge clk);
      drive_mem();
    end
    @(negedge clk);
    n_vec++;
    if (q_count !== 3'd3 || de_valid !== 1'b1 || req !== 1'b1 || addr !== RST_PC + 32'd16) begin
      n_err++;
      $display("FAIL flush_setup: q=%0d valid=%b req=%b addr=%h, want 3 1 1 %h",
               q_count, de_valid, req, addr, RST_PC + 32'd16);
    end
    mem_auto = 1'b0; ack = 1'b0; fe_enable = 1'b1; pc_wen = 1'b0;
    @(negedge clk);
    fe_enable = 1'b0;
    n_vec++;
    if (de_valid !== 1'b1 || de_pc !== RST_PC || de_insn !== insn_of(RST_PC) || q_count !== 3'd0) begin
      n_err++;
      $display("FAIL flush_keep: valid=%b pc=%h insn=%h q=%0d, want 1 %h %h 0",
               de_valid, de_pc, de_insn, q_count, RST_PC, insn_of(RST_PC));
    end
    ack = 1'b1; data = JUNK;
    @(negedge clk);
    ack = 1'b0;
    n_vec++;
    if (req !== 1'b1 || addr !== RST_PC + 32'd16 || de_pc !== RST_PC || q_count !== 3'd0) begin
      n_err++;
      $display("FAIL flush_refetch: req=%b addr=%h pc=%h q=%0d, want 1 %h %h 0",
               req, addr, de_pc, q_count, RST_PC + 32'd16, RST_PC);
    end
    de_stall = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    de_stall = 1'b1; mem_auto = 1'b1;
    repeat (4) begin
      @(negedge clk);
      drive_mem();
    end
    @(negedge clk);
    n_vec++;
    if (q_count !== 3'd3 || req !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_setup: q=%0d req=%b, want 3 1", q_count, req);
    end
    mem_auto = 1'b0; ack = 1'b0; reset_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if (q_count !== 3'd0 || de_valid !== 1'b0 || req !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_clear: q=%0d valid=%b req=%b, want 0 0 0", q_count, de_valid, req);
    end
    reset_n = 1'b1; de_stall = 1'b0;
    @(negedge clk);
    n_vec++;
    if (req !== 1'b1 || addr !== RST_PC) begin
      n_err++;
      $display("FAIL rstmid_restart: req=%b addr=%h, want 1 %h", req, addr, RST_PC);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    @(negedge clk);
    ack = 1'b1; data = JUNK; fe_enable = 1'b1; pc_wen = 1'b1; pc_in = 32'hFFFF_FFF8;
    @(negedge clk);
    ack = 1'b0; fe_enable = 1'b0; pc_wen = 1'b0;
    n_vec++;
    if (req !== 1'b1 || addr !== 32'hFFFF_FFF8 || de_valid !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_coincident: req=%b addr=%h valid=%b, want 1 fffffff8 0", req, addr, de_valid);
    end
    ack = 1'b1; data = insn_of(32'hFFFF_FFF8);
    @(negedge clk);
    n_vec++;
    if (addr !== 32'hFFFF_FFFC || de_valid !== 1'b1 || de_pc !== 32'hFFFF_FFF8) begin
      n_err++;
      $display("FAIL wrap_step: addr=%h valid=%b pc=%h, want fffffffc 1 fffffff8", addr, de_valid, de_pc);
    end
    data = insn_of(32'hFFFF_FFFC);
    @(negedge clk);
    ack = 1'b0;
    n_vec++;
    if (addr !== 32'h0000_0000 || de_pc !== 32'hFFFF_FFFC || de_insn !== insn_of(32'hFFFF_FFFC)) begin
      n_err++;
      $display("FAIL wrap_zero: addr=%h pc=%h insn=%h, want 00000000 fffffffc %h",
               addr, de_pc, de_insn, insn_of(32'hFFFF_FFFC));
    end
  endtask

  // Model: every acked word joins an in-order list; decode consumes its head.
  task automatic test_random_stream();
    logic [63:0] exp_q[$];
    logic [31:0] ref_fetch;
    int          occ;
    do_reset();
    mem_auto = 1'b1; mem_maxlat = 3; mem_lat = $urandom_range(3, 0); ref_fetch = RST_PC;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      occ = int'(q_count) + (de_valid === 1'b1 ? 1 : 0);
      n_vec++;
      if (occ != exp_q.size()) begin
        n_err++;
        $display("FAIL rnd_occupancy[%0d]: q+valid=%0d want %0d", c, occ, exp_q.size());
      end
      n_vec++;
      if (req !== (exp_q.size() < DEPTH + 1)) begin
        n_err++;
        $display("FAIL rnd_credit[%0d]: req=%b with %0d held, want %b", c, req, exp_q.size(),
                 exp_q.size() < DEPTH + 1);
      end
      if (req === 1'b1) begin
        n_vec++;
        if (addr !== ref_fetch) begin
          n_err++;
          $display("FAIL rnd_addr[%0d]: addr=%h want %h", c, addr, ref_fetch);
        end
      end
      de_stall = ($urandom_range(9, 0) < 4);
      if (de_valid === 1'b1 && !de_stall) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL rnd_order[%0d]: pc=%h presented with nothing fetched", c, de_pc);
        end else begin
          if ({de_pc, de_insn} !== exp_q[0]) begin
            n_err++;
            $display("FAIL rnd_order[%0d]: pc=%h insn=%h want %h %h", c, de_pc, de_insn,
                     exp_q[0][63:32], exp_q[0][31:0]);
          end
          void'(exp_q.pop_front());
        end
      end
      drive_mem();
      if (ack) begin
        exp_q.push_back({addr, data});
        ref_fetch = ref_fetch + 32'd4;
      end
    end
    mem_auto = 1'b0;
    @(negedge clk);
    ack = 1'b0; de_stall = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; de_stall = 1'b0; fe_enable = 1'b0; pc_wen = 1'b0;
    pc_in = '0; ack = 1'b0; data = '0;
    mem_auto = 1'b0; ctrl_on = 1'b0; ctrl_pc = '0; mem_lat = 0; mem_maxlat = 0;
    test_reset();
    test_sequential();
    test_stall_fill();
    test_stop_on_ctrl();
    test_redirect_drop();
    test_flush_stalled();
    test_reset_mid();
    test_wrap();
    test_random_stream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached after %0d vectors", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
